// File: rtl/nes_pkg.sv
// NES pad reader shared definitions.
// Button indices, code values and FSM states.
package nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [4:0] CODE_NONE     = 5'd12;
  localparam logic [4:0] CODE_DIR_BASE = 5'd0;
  localparam logic [4:0] CODE_ACT_BASE = 5'd4;
  localparam logic [4:0] CODE_MOD_BASE = 5'd8;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_e;

endpackage

// File: rtl/nes_code_enc.sv
// Priority encoder: debounced buttons to 5-bit code.
// Direction wins over actions; A turns a direction into a modified code.
module nes_code_enc
  import nes_pkg::*;
(
  input  logic [7:0] buttons_i,
  output logic [4:0] code_o
);

  logic [3:0] dir;
  logic [4:0] d;

  // Direction index with priority Up > Down > Left > Right
  always_comb begin
    dir = {buttons_i[BTN_RIGHT], buttons_i[BTN_LEFT],
           buttons_i[BTN_DOWN], buttons_i[BTN_UP]};
    d = 5'd0;
    priority case (1'b1)
      dir[0]:  d = 5'd0;
      dir[1]:  d = 5'd1;
      dir[2]:  d = 5'd2;
      default: d = 5'd3;
    endcase
  end

  // Final code: A+dir, dir, then A/B/Select/Start, else none
  always_comb begin
    code_o = CODE_NONE;
    if (|dir) begin
      if (buttons_i[BTN_A]) code_o = CODE_MOD_BASE + d;
      else                  code_o = CODE_DIR_BASE + d;
    end else if (buttons_i[BTN_A]) begin
      code_o = CODE_ACT_BASE;
    end else if (buttons_i[BTN_B]) begin
      code_o = CODE_ACT_BASE + 5'd1;
    end else if (buttons_i[BTN_SELECT]) begin
      code_o = CODE_ACT_BASE + 5'd2;
    end else if (buttons_i[BTN_START]) begin
      code_o = CODE_ACT_BASE + 5'd3;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller reader: latch/clock generation, serial read,
// two-frame debounce and registered button code with change strobe.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int LATCH_CYC = 144,
  parameter int HALF_CYC  = 72,
  parameter int POLL_CYC  = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic [4:0] nes_code,
  output logic       code_strobe
);

  localparam int PW     = $clog2(POLL_CYC);
  localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int HW     = $clog2(PH_MAX + 1);

  logic [1:0]    sync_q;
  logic          pressed;
  logic [PW-1:0] poll_q;
  logic [PW-1:0] poll_d;
  logic          poll_wrap;
  logic [HW-1:0] phase_q;
  logic          latch_end;
  logic          half_end;
  logic [2:0]    bit_q;
  state_e        state_q;
  logic          latch_q;
  logic          pulse_q;
  logic [7:0]    shift_q;
  logic [7:0]    prev_q;
  logic [7:0]    buttons_q;
  logic [4:0]    code_d;
  logic [4:0]    code_q;
  logic          strobe_q;

  // Two-flop synchroniser; idle level is released (high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], nes_data};
  end

  assign pressed = ~sync_q[1];

  assign poll_wrap = (poll_q == PW'(POLL_CYC - 1));
  assign poll_d    = poll_wrap ? '0 : poll_q + 1'b1;

  // Free-running frame-rate counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) poll_q <= '0;
    else          poll_q <= poll_d;
  end

  assign latch_end = (phase_q == HW'(LATCH_CYC - 1));
  assign half_end  = (phase_q == HW'(HALF_CYC - 1));

  // Frame FSM: latch, 8 samples with 7 shift pulses, debounce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= 3'd0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      shift_q   <= 8'h00;
      prev_q    <= 8'h00;
      buttons_q <= 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (poll_wrap) begin
            state_q <= LATCH;
            latch_q <= 1'b1;
            phase_q <= '0;
            bit_q   <= 3'd0;
          end
        end
        LATCH: begin
          if (latch_end) begin
            state_q <= LOW;
            latch_q <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        LOW: begin
          if (half_end) begin
            shift_q[bit_q] <= pressed;
            phase_q        <= '0;
            if (bit_q == 3'd7) begin
              state_q <= DONE;
            end else begin
              state_q <= HIGH;
              pulse_q <= 1'b1;
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        HIGH: begin
          if (half_end) begin
            state_q <= LOW;
            pulse_q <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        DONE: begin
          if (shift_q == prev_q) buttons_q <= shift_q;
          prev_q  <= shift_q;
          bit_q   <= 3'd0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          latch_q <= 1'b0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  nes_code_enc u_enc (
    .buttons_i (buttons_q),
    .code_o    (code_d)
  );

  // Registered code with one-cycle pulse on every value change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q   <= CODE_NONE;
      strobe_q <= 1'b0;
    end else begin
      code_q   <= code_d;
      strobe_q <= (code_d != code_q);
    end
  end

  assign nes_latch   = latch_q;
  assign nes_pulse   = pulse_q;
  assign buttons     = buttons_q;
  assign nes_code    = code_q;
  assign code_strobe = strobe_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader with a CD4021 pad model.
// Strobed codes are checked against a queue of expected codes.
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic [4:0] nes_code;
  logic       code_strobe;

  logic [7:0] pad = 8'h00;
  logic [7:0] sr = 8'hFF;
  logic       unplugged = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  nes_pad_reader #(
    .LATCH_CYC (4),
    .HALF_CYC  (2),
    .POLL_CYC  (100)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .nes_data    (nes_data),
    .nes_latch   (nes_latch),
    .nes_pulse   (nes_pulse),
    .buttons     (buttons),
    .nes_code    (nes_code),
    .code_strobe (code_strobe)
  );

  assign nes_data = unplugged ? 1'b1 : sr[0];

  always @(posedge nes_latch or posedge nes_pulse) begin
    if (nes_latch) sr <= ~pad;
    else           sr <= {1'b1, sr[7:1]};
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && code_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL strobe: unexpected, nes_code=%0d, expected none",
                 nes_code);
      end else begin
        chk("strobe code", 32'(nes_code), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_latch(output int cyc);
    cyc = 0;
    while (nes_latch !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL latch timeout: got none, expected latch");
    end
  endtask

  task automatic frame();
    int c;
    wait_latch(c);
    repeat (40) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic drained(input string name);
    chk(name, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int c, nl, np, nr, k, g;
    logic pp;

    repeat (5) @(negedge clk);
    chk("rst latch", 32'(nes_latch), 0);
    chk("rst pulse", 32'(nes_pulse), 0);
    chk("rst buttons", 32'(buttons), 0);
    chk("rst code", 32'(nes_code), 12);
    chk("rst strobe", 32'(code_strobe), 0);

    reset_n = 1'b1;
    wait_latch(c);
    chk("first latch delay", 32'(c), 100);
    nl = 0; np = 0; nr = 0; pp = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (nes_latch) nl++;
      if (nes_pulse) np++;
      if (nes_pulse && !pp) nr++;
      pp = nes_pulse;
      @(negedge clk);
    end
    chk("latch width", 32'(nl), 4);
    chk("pulse high cycles", 32'(np), 14);
    chk("pulse count", 32'(nr), 7);
    chk("idle code", 32'(nes_code), 12);

    pad = 8'h10;
    exp_q.push_back(5'd0);
    frame();
    chk("up 1 frame buttons", 32'(buttons), 0);
    frame();
    chk("up buttons", 32'(buttons), 32'h10);
    chk("up code", 32'(nes_code), 0);
    frame();
    chk("up held code", 32'(nes_code), 0);
    drained("up drained");

    pad = 8'h41;
    exp_q.push_back(5'd10);
    frames(2);
    chk("a+left code", 32'(nes_code), 10);
    chk("a+left buttons", 32'(buttons), 32'h41);
    pad = 8'h01;
    exp_q.push_back(5'd4);
    frames(2);
    chk("a code", 32'(nes_code), 4);
    pad = 8'h00;
    exp_q.push_back(5'd12);
    frames(2);
    chk("release code", 32'(nes_code), 12);
    drained("a+left drained");

    pad = 8'h28;
    exp_q.push_back(5'd1);
    frames(2);
    chk("start+down code", 32'(nes_code), 1);
    pad = 8'h2C;
    frame();
    chk("glitch buttons", 32'(buttons), 32'h28);
    pad = 8'h28;
    frames(2);
    chk("post glitch buttons", 32'(buttons), 32'h28);
    chk("post glitch code", 32'(nes_code), 1);
    drained("glitch drained");

    pad = 8'h00;
    exp_q.push_back(5'd12);
    frames(2);
    unplugged = 1'b1;
    pad = 8'hFF;
    frames(3);
    chk("unplugged code", 32'(nes_code), 12);
    chk("unplugged buttons", 32'(buttons), 0);
    unplugged = 1'b0;
    exp_q.push_back(5'd8);
    frames(2);
    chk("all code", 32'(nes_code), 8);
    chk("all buttons", 32'(buttons), 32'hFF);
    drained("all drained");

    wait_latch(c);
    k = 0; g = 0; pp = 1'b0;
    while (k < 4 && g < 60) begin
      @(negedge clk);
      g++;
      if (nes_pulse && !pp) k++;
      pp = nes_pulse;
    end
    chk("pulse 4 seen", 32'(k), 4);
    reset_n = 1'b0;
    #1;
    chk("mid rst latch", 32'(nes_latch), 0);
    chk("mid rst pulse", 32'(nes_pulse), 0);
    chk("mid rst code", 32'(nes_code), 12);
    chk("mid rst buttons", 32'(buttons), 0);
    pad = 8'h80;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_latch(c);
    chk("relatch delay", 32'(c), 100);
    repeat (40) @(negedge clk);
    chk("right 1 frame code", 32'(nes_code), 12);
    exp_q.push_back(5'd3);
    frame();
    chk("right code", 32'(nes_code), 3);
    chk("right buttons", 32'(buttons), 32'h80);
    drained("final drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
